mlp_frame_sequencer: RTL and testbench
======================================

// Module: mlp_frame_sequencer
// PURPOSE
//  Clocked front-end for the combinational bespoke MLP (top: inp -> out).
//  - Collects NUM_A features arriving serially (one WIDTH_A-bit feature per accepted beat) into a frame.
//  - Drives the frame onto the MLP's parallel inp bus and waits SETTLE_CYCLES for the slow printed logic to settle.
//  - Captures the class index from out and offers it downstream on a valid/ready result port.
// PARAMETERS
//  NUM_A          8    features per frame
//  WIDTH_A        4    bits per feature (unsigned)
//  OUTWIDTH       2    class-index width from MLP
//  SETTLE_CYCLES  4    clocks between frame complete and out capture (>=1)
// PORTS
//  clk         in   1                 clock
//  rst         in   1                 async active-high reset
//  feat_valid  in   1                 feature beat valid
//  feat_ready  out  1                 sequencer can accept a beat
//  feat_data   in   WIDTH_A           feature value
//  feat_last   in   1                 marks final feature of a frame
//  inp         out  NUM_A*WIDTH_A     frame to MLP; feature i at [(i+1)*WIDTH_A-1:i*WIDTH_A]
//  out         in   OUTWIDTH          MLP class index (combinational from inp)
//  res_valid   out  1                 result valid
//  res_ready   in   1                 downstream accepts result
//  res_class   out  OUTWIDTH          captured class
//  err_align   out  1                 1-cycle pulse: frame dropped (feat_last misaligned)
//  busy        out  1                 high in SETTLE or RESULT
// BEHAVIOUR
//  Interface: one clock (clk); reset rst asynchronous, active-high.
//  Reset values: inp=0, res_class=0, res_valid=0, err_align=0, busy=0, feat_ready=1, idx=0, state=FILL.
//  Beat accepted when feat_valid & feat_ready (rising edge). Data/last sampled only then.
//  States:
//   FILL    feat_ready=1. Beat k (idx=k) writes feature slot k of inp; idx++.
//           Beat with idx==NUM_A-1 and feat_last=1 -> SETTLE, idx<=0, settle cnt<=0.
//           feat_last=1 with idx<NUM_A-1, or feat_last=0 at idx==NUM_A-1:
//           frame dropped, idx<=0, err_align pulses next cycle, stay FILL.
//           The offending beat is consumed; inp is not cleared.
//   SETTLE  feat_ready=0; inp held stable. cnt increments each clk.
//           When cnt==SETTLE_CYCLES-1: res_class<=out, res_valid<=1 -> RESULT.
//   RESULT  feat_ready=0, res_valid=1, res_class stable.
//           res_ready=1 -> res_valid<=0 next edge -> FILL.
//  Latency: accepting the last beat at edge T -> out sampled at edge T+SETTLE_CYCLES; res_valid high from then.
//  Throughput: max one frame per NUM_A+SETTLE_CYCLES+1 clocks with res_ready tied 1.
//  res_valid never drops without res_ready; res_class must not change while res_valid=1.
//  feat_ready is a pure function of state (no combinational path from feat_valid).
//  Reset mid-operation: immediate return to reset values; a partial frame or pending result is discarded.
//  idx width $clog2(NUM_A), minimum 1; cnt width $clog2(SETTLE_CYCLES+1). Neither may wrap in legal operation.
//  busy = (state!=FILL).
// STRUCTURE
//  Package mlp_io_pkg:
//   - state enum {FILL, SETTLE, RESULT}
//   - default NUM_A / WIDTH_A / OUTWIDTH constants, shared with the MLP top and its bench.
//  One sub-module, mlp_settle_timer: start pulse -> done pulse after SETTLE_CYCLES; same clk/rst.
//  Top-level flow: mlp_frame_sequencer -> top (MLP) -> out fed back to mlp_frame_sequencer.
// TESTING
//  1 Reset: assert rst mid-SETTLE -> all outputs return to reset values asynchronously; feat_ready=1 after release.
//  2 Nominal frame: send features 1,2,..,8 with last on the 8th -> inp=32'h87654321;
//    out sampled exactly 4 clks later; res_valid=1 with res_class=out.
//  3 Backpressure: res_ready=0 for 10 clks -> res_valid and res_class stable, feat_ready=0;
//    res_ready=1 -> FILL next clk.
//  4 Early last: feat_last on 5th beat -> err_align pulses once, no res_valid;
//    next 8-beat frame with correct last completes normally.
//  5 Missing last: 8 beats with feat_last=0 -> err_align pulse, frame dropped.
//  6 Streaming vs golden: 1000 frames, feat_valid random 50%, res_ready=1;
//    compare res_class against the golden output file from the existing MLP flow, zero mismatches.

Source files
------------

// File: rtl/mlp_io_pkg.sv
// ============================================================================
// Module      : mlp_io_pkg
// Description : Shared frame geometry and sequencer state type for the MLP
//               front-end, its MLP top and benches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mlp_io_pkg;

    localparam int c_num_a    = 8;
    localparam int c_width_a  = 4;
    localparam int c_outwidth = 2;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESULT = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/mlp_settle_timer.sv
// ============================================================================
// Module      : mlp_settle_timer
// Description : One-shot timer; a start pulse yields a single done pulse
//               SETTLE_CYCLES clocks later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlp_settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int                c_cw   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_cw-1:0]   c_last = c_cw'(SETTLE_CYCLES - 1);

    logic            r_run;
    logic [c_cw-1:0] r_cnt;

    // The counter parks on its final value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
        end else if (r_run) begin
            if (r_cnt == c_last) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign done = r_run & (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/mlp_frame_sequencer.sv
// ============================================================================
// Module      : mlp_frame_sequencer
// Description : Serial-to-parallel frame builder feeding the combinational
//               MLP, waits for settling, and returns the class on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlp_frame_sequencer
    import mlp_io_pkg::*;
#(
    parameter int NUM_A         = c_num_a,
    parameter int WIDTH_A       = c_width_a,
    parameter int OUTWIDTH      = c_outwidth,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       feat_valid,
    output logic                       feat_ready,
    input  logic [WIDTH_A-1:0]         feat_data,
    input  logic                       feat_last,
    output logic [NUM_A*WIDTH_A-1:0]   inp,
    input  logic [OUTWIDTH-1:0]        out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUTWIDTH-1:0]        res_class,
    output logic                       err_align,
    output logic                       busy
);

    localparam int              c_iw       = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam logic [c_iw-1:0] c_idx_last = c_iw'(NUM_A - 1);

    seq_state_t                 r_state;
    logic [c_iw-1:0]            r_idx;
    logic [NUM_A*WIDTH_A-1:0]   r_inp;
    logic [OUTWIDTH-1:0]        r_res_class;
    logic                       r_res_valid;
    logic                       r_err_align;
    logic                       r_busy;
    logic                       r_feat_ready;

    logic w_accept;
    logic w_last_slot;
    logic w_start;
    logic w_done;

    // feat_ready is registered and only high in FILL, so accept implies FILL.
    assign w_accept    = feat_valid & r_feat_ready;
    assign w_last_slot = (r_idx == c_idx_last);
    assign w_start     = w_accept & feat_last & w_last_slot;

    mlp_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .done  (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_idx        <= '0;
            r_inp        <= '0;
            r_res_class  <= '0;
            r_res_valid  <= 1'b0;
            r_err_align  <= 1'b0;
            r_busy       <= 1'b0;
            r_feat_ready <= 1'b1;
        end else begin
            r_err_align <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        for (int i = 0; i < NUM_A; i++) begin
                            if (r_idx == c_iw'(i)) begin
                                r_inp[i*WIDTH_A +: WIDTH_A] <= feat_data;
                            end
                        end
                        // A last flag off the final slot, either way, drops the frame.
                        if (feat_last != w_last_slot) begin
                            r_idx       <= '0;
                            r_err_align <= 1'b1;
                        end else if (feat_last) begin
                            r_idx        <= '0;
                            r_state      <= ST_SETTLE;
                            r_feat_ready <= 1'b0;
                            r_busy       <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (w_done) begin
                        r_res_class <= out;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        r_res_valid  <= 1'b0;
                        r_state      <= ST_FILL;
                        r_feat_ready <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_FILL;
                    r_idx        <= '0;
                    r_res_valid  <= 1'b0;
                    r_feat_ready <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign feat_ready = r_feat_ready;
    assign inp        = r_inp;
    assign res_valid  = r_res_valid;
    assign res_class  = r_res_class;
    assign err_align  = r_err_align;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mlp_frame_sequencer.sv
// ============================================================================
// Module      : tb_mlp_frame_sequencer
// Description : Randomized scoreboard bench for mlp_frame_sequencer with a
//               behavioural stand-in for the combinational MLP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mlp_frame_sequencer;
    import mlp_io_pkg::*;

    localparam int NA = c_num_a;
    localparam int WA = c_width_a;
    localparam int OW = c_outwidth;
    localparam int SC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              feat_valid;
    logic              feat_ready;
    logic [WA-1:0]     feat_data;
    logic              feat_last;
    logic [NA*WA-1:0]  inp;
    logic [OW-1:0]     out;
    logic              res_valid;
    logic              res_ready;
    logic [OW-1:0]     res_class;
    logic              err_align;
    logic              busy;

    mlp_frame_sequencer #(
        .NUM_A(NA), .WIDTH_A(WA), .OUTWIDTH(OW), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .rst(rst), .feat_valid(feat_valid), .feat_ready(feat_ready),
        .feat_data(feat_data), .feat_last(feat_last), .inp(inp), .out(out),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .err_align(err_align), .busy(busy)
    );

    // Stand-in for the printed MLP: any fixed function of the whole frame.
    function automatic logic [OW-1:0] mlp_fn(input logic [NA*WA-1:0] v);
        int s;
        s = 0;
        for (int i = 0; i < NA; i++) s += int'(v[i*WA +: WA]) * (i + 3);
        return OW'(s ^ (s >> 2));
    endfunction

    assign out = mlp_fn(inp);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0]    cls;
        logic [NA*WA-1:0] frame;
        int               cyc;
    } exp_t;

    exp_t          sb[$];
    int            err_q[$];
    logic [WA-1:0] fr[NA];
    int            fill_cnt = 0;
    int            tests = 0;
    int            fails = 0;
    bit            rr_rand = 1'b0;
    bit            rr_val  = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Reference: a frame is good only if last arrives exactly on its NA-th feature.
    task automatic model_accept(input logic [WA-1:0] d, input bit l);
        exp_t e;
        fr[fill_cnt] = d;
        if (l && fill_cnt == NA - 1) begin
            e.frame = '0;
            for (int i = 0; i < NA; i++) e.frame[i*WA +: WA] = fr[i];
            e.cls = mlp_fn(e.frame);
            e.cyc = cyc;
            sb.push_back(e);
            fill_cnt = 0;
        end else if (l || fill_cnt == NA - 1) begin
            err_q.push_back(cyc);
            fill_cnt = 0;
        end else begin
            fill_cnt++;
        end
    endtask

    task automatic send_frame(input int nbeats, input int last_pos, input bit seq, input int gap_pct);
        for (int k = 0; k < nbeats; k++) begin
            logic [WA-1:0] d;
            bit            l;
            bit            sent;
            int            waited;
            d      = seq ? WA'(k + 1) : WA'($urandom);
            l      = (k == last_pos);
            sent   = 1'b0;
            waited = 0;
            while (!sent) begin
                @(negedge clk);
                if ($urandom_range(0, 99) < gap_pct) begin
                    feat_valid = 1'b0;
                end else begin
                    feat_valid = 1'b1;
                    feat_data  = d;
                    feat_last  = l;
                    if (feat_ready) begin
                        model_accept(d, l);
                        sent = 1'b1;
                    end
                end
                waited++;
                if (waited > 500) begin
                    check("ready_timeout", 64'd0, 64'd1);
                    finish_tb();
                end
            end
        end
        @(negedge clk);
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        #1 res_ready = rr_rand ? ($urandom_range(0, 99) < 60) : rr_val;
    end

    // Monitor: pops expectations whenever the DUT presents a result or error.
    bit            hs;
    bit            prev_valid = 1'b0;
    logic [OW-1:0] prev_class;
    always @(posedge clk) hs <= res_valid & res_ready;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            exp_t e;
            int   c;
            check("busy_vs_ready", {63'd0, busy}, {63'd0, ~feat_ready});
            if (res_valid) check("ready_in_result", {63'd0, feat_ready}, 64'd0);
            if (prev_valid && !hs) begin
                check("valid_hold", {63'd0, res_valid}, 64'd1);
                check("class_hold", 64'(res_class), 64'(prev_class));
            end
            if (res_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("res_class", 64'(res_class), 64'(e.cls));
                    check("frame_inp", 64'(inp), 64'(e.frame));
                    check("res_latency", 64'(cyc - e.cyc), 64'(SC + 1));
                end
            end
            if (err_align) begin
                if (err_q.size() == 0) begin
                    check("unexpected_err", 64'd1, 64'd0);
                end else begin
                    c = err_q.pop_front();
                    check("err_latency", 64'(cyc - c), 64'd1);
                end
            end
            prev_valid = res_valid;
            prev_class = res_class;
        end
    end

    initial begin
        int n;
        rst        = 1'b1;
        feat_valid = 1'b0;
        feat_data  = '0;
        feat_last  = 1'b0;
        res_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_inp", 64'(inp), 64'd0);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_feat_ready", {63'd0, feat_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {63'd0, err_align}, 64'd0);
        check("rst_class", 64'(res_class), 64'd0);
        #2 rst = 1'b0;

        // Nominal frame 1..8, then hold the result under backpressure.
        rr_val = 1'b0;
        send_frame(NA, NA - 1, 1'b1, 0);
        n = 0;
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        check("nominal_valid", {63'd0, res_valid}, 64'd1);
        check("nominal_inp", 64'(inp), 64'h87654321);
        repeat (10) @(negedge clk);
        check("bp_feat_ready", {63'd0, feat_ready}, 64'd0);
        check("bp_res_valid", {63'd0, res_valid}, 64'd1);
        rr_val = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hs_feat_ready", {63'd0, feat_ready}, 64'd1);
        check("hs_res_valid", {63'd0, res_valid}, 64'd0);

        // Early last, recovery, missing last, recovery.
        send_frame(5, 4, 1'b0, 0);
        send_frame(NA, NA - 1, 1'b0, 0);
        send_frame(NA, -1, 1'b0, 0);
        send_frame(NA, NA - 1, 1'b0, 30);

        // Asynchronous reset while settling discards the pending result.
        send_frame(NA, NA - 1, 1'b0, 0);
        check("in_settle", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        err_q.delete();
        fill_cnt = 0;
        check("arst_res_valid", {63'd0, res_valid}, 64'd0);
        check("arst_feat_ready", {63'd0, feat_ready}, 64'd1);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_inp", 64'(inp), 64'd0);
        check("arst_class", 64'(res_class), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {63'd0, feat_ready}, 64'd1);

        // Streaming: random gaps, occasional misaligned frames, later random backpressure.
        for (int f = 0; f < 1000; f++) begin
            int r;
            if (f == 500) rr_rand = 1'b1;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                n = $urandom_range(1, NA - 1);
                send_frame(n, n - 1, 1'b0, 50);
            end else if (r == 1) begin
                send_frame(NA, -1, 1'b0, 50);
            end else begin
                send_frame(NA, NA - 1, 1'b0, 50);
            end
        end
        rr_rand = 1'b0;
        rr_val  = 1'b1;
        n = 0;
        while ((sb.size() != 0 || err_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
        check("drain_results", 64'(sb.size()), 64'd0);
        check("drain_errors", 64'(err_q.size()), 64'd0);
        finish_tb();
    end

endmodule

`default_nettype wire
